// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic instructions into 32-bit machine words and
// writes them to consecutive instruction-memory addresses. Mirrors the
// CPU control decoder's field layout. Illegal mnemonics are consumed
// without a write and raise a sticky error flag.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err_illegal
);

    localparam logic [0:0]      ST_LOAD = 1'b0;
    localparam logic [0:0]      ST_FULL = 1'b1;
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};

    // Returns {legal, word}; illegal mnemonics give legal=0 and a zero word.
    function automatic logic [32:0] encode(
        input logic [3:0]  f_op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [15:0] f_imm,
        input logic [25:0] f_target
    );
        logic [32:0] res;
        case (f_op)
            4'd0:    res = {1'b1, 6'd25, f_rs, f_rt, f_rd, 5'd0, 6'd32};
            4'd1:    res = {1'b1, 6'd25, f_rs, f_rt, f_rd, 5'd0, 6'd34};
            4'd2:    res = {1'b1, 6'd25, f_rs, f_rt, f_rd, 5'd0, 6'd36};
            4'd3:    res = {1'b1, 6'd25, f_rs, f_rt, f_rd, 5'd0, 6'd37};
            4'd4:    res = {1'b1, 6'd25, f_rs, f_rt, f_rd, 5'd0, 6'd50};
            4'd5:    res = {1'b1, 6'd47, f_rs, f_rt, f_imm};
            4'd6:    res = {1'b1, 6'd48, f_rs, f_rt, f_imm};
            4'd7:    res = {1'b1, 6'd49, f_rs, f_rt, f_imm};
            4'd8:    res = {1'b1, 6'd50, f_rs, f_rt, f_imm};
            4'd9:    res = {1'b1, 6'd51, f_rs, f_rt, f_imm};
            4'd10:   res = {1'b1, 6'd2, f_target};
            default: res = {1'b0, 32'd0};
        endcase
        return res;
    endfunction

    logic [0:0]        state_r;
    logic [0:0]        state_next_s;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_inc_s;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              err_r;
    logic              accept_s;
    logic [32:0]       enc_s;

    assign full        = (state_r == ST_FULL);
    assign in_ready    = ~full & ~clear;
    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign word_count  = count_r;
    assign err_illegal = err_r;

    // Handshake, encoding and next-state decision for the current request.
    always_comb begin
        accept_s     = in_valid & in_ready;
        enc_s        = encode(op, rs, rt, rd, imm, target);
        count_inc_s  = count_r + {{ADDR_W{1'b0}}, 1'b1};
        state_next_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && enc_s[32] && (count_inc_s == DEPTH)) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_FULL: state_next_s = ST_FULL;
            default: state_next_s = ST_LOAD;
        endcase
    end

    // State, pointer/count, sticky error and registered write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_LOAD;
            count_r     <= {(ADDR_W+1){1'b0}};
            err_r       <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'd0;
        end else if (clear) begin
            state_r  <= ST_LOAD;
            count_r  <= {(ADDR_W+1){1'b0}};
            err_r    <= 1'b0;
            mem_we_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            mem_we_r <= 1'b0;
            if (accept_s) begin
                if (enc_s[32]) begin
                    mem_we_r    <= 1'b1;
                    mem_addr_r  <= count_r[ADDR_W-1:0];
                    mem_wdata_r <= enc_s[31:0];
                    count_r     <= count_inc_s;
                end else begin
                    err_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (small memory so the full path is
// reachable). Expected writes are queued when a request is accepted and
// compared against each mem_we strobe.
module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n, clear, in_valid, in_ready;
    logic [3:0]    op;
    logic [4:0]    rs, rt, rd;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;
    logic          full, err_illegal;

    int checks = 0;
    int errors = 0;

    logic [AW+31:0] exp_q[$];
    int   exp_count;
    logic exp_full, exp_err;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .target(target), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .word_count(word_count), .full(full),
        .err_illegal(err_illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", {32'd0, mem_wdata}, 64'd0);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                check("sb_addr", {62'd0, mem_addr}, {62'd0, e[AW+31:32]});
                check("sb_data", {32'd0, mem_wdata}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic set_req(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [15:0] i, input logic [25:0] g);
        in_valid = 1'b1; op = o; rs = s; rt = t; rd = d; imm = i; target = g;
    endtask

    // One clock with the current inputs; legal/word describe the request.
    task automatic cycle(input logic legal, input logic [31:0] word);
        logic acc, exp_ready;
        #1;
        exp_ready = !exp_full && !clear;
        if (rst_n) check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
        acc = in_valid && exp_ready && rst_n;
        if (!rst_n || clear) begin
            exp_count = 0; exp_full = 1'b0; exp_err = 1'b0;
        end else if (acc) begin
            if (legal) begin
                exp_q.push_back({exp_count[AW-1:0], word});
                exp_count++;
                if (exp_count == (1 << AW)) exp_full = 1'b1;
            end else begin
                exp_err = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("mem_we", {63'd0, mem_we}, {63'd0, (acc && legal)});
        check("word_count", {61'd0, word_count}, 64'(exp_count));
        check("full", {63'd0, full}, {63'd0, exp_full});
        check("err_illegal", {63'd0, err_illegal}, {63'd0, exp_err});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, {63'd0, mem_we}, 64'd0);
        check({tag, "_addr"}, {62'd0, mem_addr}, 64'd0);
        check({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        op = 4'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'd0; target = 26'd0;
        exp_count = 0; exp_full = 1'b0; exp_err = 1'b0;

        // Reset state
        cycle(1'b1, 32'd0);
        cycle(1'b1, 32'd0);
        check_zero("rst");
        rst_n = 1'b1;

        // Single ADD, then idle
        set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0); cycle(1'b1, 32'h64221820);
        in_valid = 1'b0; cycle(1'b1, 32'd0);
        clear = 1'b1; cycle(1'b1, 32'd0); clear = 1'b0;

        // Back-to-back MUL, LW, JMP
        set_req(4'd4, 5'd1, 5'd2, 5'd5, 16'd0, 26'd0);   cycle(1'b1, 32'h64222832);
        set_req(4'd5, 5'd0, 5'd4, 5'd0, 16'd8, 26'd0);   cycle(1'b1, 32'hBC040008);
        set_req(4'd10, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10); cycle(1'b1, 32'h08000010);
        in_valid = 1'b0; cycle(1'b1, 32'd0);
        check("drain1", 64'(exp_q.size()), 64'd0);
        clear = 1'b1; cycle(1'b1, 32'd0); clear = 1'b0;

        // Illegal op between two ADDIs
        set_req(4'd8, 5'd1, 5'd2, 5'd0, 16'd5, 26'd0);       cycle(1'b1, 32'hC8220005);
        set_req(4'd12, 5'd7, 5'd7, 5'd7, 16'h1111, 26'h55);  cycle(1'b0, 32'd0);
        set_req(4'd8, 5'd3, 5'd4, 5'd9, 16'hFFFF, 26'd0);    cycle(1'b1, 32'hC864FFFF);
        in_valid = 1'b0; cycle(1'b1, 32'd0);
        clear = 1'b1; cycle(1'b1, 32'd0); clear = 1'b0;

        // Fill the memory; fifth request held but not consumed
        set_req(4'd1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);       cycle(1'b1, 32'h64853022);
        set_req(4'd2, 5'd0, 5'd0, 5'd1, 16'd0, 26'd0);       cycle(1'b1, 32'h64000824);
        set_req(4'd3, 5'd31, 5'd31, 5'd31, 16'd0, 26'd0);    cycle(1'b1, 32'h67FFF825);
        set_req(4'd6, 5'd2, 5'd3, 5'd0, 16'h1234, 26'd0);    cycle(1'b1, 32'hC0431234);
        set_req(4'd7, 5'd1, 5'd1, 5'd0, 16'hFFFE, 26'd0);
        cycle(1'b1, 32'hC421FFFE);
        cycle(1'b1, 32'hC421FFFE);
        cycle(1'b1, 32'hC421FFFE);
        clear = 1'b1; cycle(1'b1, 32'hC421FFFE); clear = 1'b0;
        cycle(1'b1, 32'hC421FFFE);
        in_valid = 1'b0; cycle(1'b1, 32'd0);
        check("drain2", 64'(exp_q.size()), 64'd0);
        clear = 1'b1; cycle(1'b1, 32'd0); clear = 1'b0;

        // ORI ignores rd; JMP ignores rs/rt/rd/imm
        set_req(4'd9, 5'd0, 5'd7, 5'd31, 16'hABCD, 26'd0);            cycle(1'b1, 32'hCC07ABCD);
        set_req(4'd10, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF);  cycle(1'b1, 32'h0BFFFFFF);
        in_valid = 1'b0; cycle(1'b1, 32'd0);
        clear = 1'b1; cycle(1'b1, 32'd0); clear = 1'b0;

        // clear together with in_valid: nothing accepted
        set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        clear = 1'b1; cycle(1'b1, 32'h64221820); clear = 1'b0;
        in_valid = 1'b0; cycle(1'b1, 32'd0);

        // Reset one cycle after an accept, request still valid
        set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0); cycle(1'b1, 32'h64221820);
        set_req(4'd1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
        rst_n = 1'b0; cycle(1'b1, 32'h64853022);
        check_zero("midrst");
        rst_n = 1'b1; in_valid = 1'b0; cycle(1'b1, 32'd0);
        check("drain3", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential instruction encoder and loader, the inverse of the CPU's control decoder. It accepts symbolic instructions (a mnemonic code plus register, immediate and jump-target fields) over a valid/ready handshake. It packs each one into the 32-bit instruction format the decoder expects and writes it to consecutive instruction-memory addresses. It sits between the test/boot host and the instruction memory write port.

## Interface

- ADDR_W, 8, instruction-memory address width; depth = 2^ADDR_W words
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- clear  in  1  synchronous restart: pointer to 0, clears full/err; higher priority than in_valid
- in_valid  in  1  request holds a valid instruction
- in_ready  out  1  encoder accepts this cycle
- op  in  4  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 LW, 6 SW, 7 BNE, 8 ADDI, 9 ORI, 10 JMP, 11-15 illegal
- rs, rt, rd  in  5 each  register fields
- imm  in  16  immediate / branch offset
- target  in  26  jump target
- mem_we  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  encoded instruction word
- word_count  out  ADDR_W+1  legal words written since reset/clear
- full  out  1  memory filled, no further accepts
- err_illegal  out  1  sticky: an illegal op was accepted

## Operation

- Accept = in_valid & in_ready; in_ready = ~full & ~clear.
- Encoding (unused bits 0):
  - R-type (ops 0-4): [31:26]=25, [25:21]=rs, [20:16]=rt, [15:11]=rd, [10:6]=0, [5:0]=funct: ADD 32, SUB 34, AND 36, OR 37, MUL 50.
  - I-type: [31:26]=opcode, [25:21]=rs, [20:16]=rt, [15:0]=imm; opcodes LW 47, SW 48, BNE 49, ADDI 50, ORI 51. rd input ignored (LW/ADDI/ORI destination is rt).
  - JMP: [31:26]=2, [25:0]=target; rs/rt/rd/imm ignored.
- Legal accept: write word registered at pointer; pointer and word_count +1.
- Illegal accept: consumed, no write, pointer/count unchanged, err_illegal set until reset/clear.
- State machine: LOAD (accepting) -> FULL when accept makes word_count = 2^ADDR_W; FULL -> LOAD only on clear or reset. In FULL, in_valid is ignored and inputs are not consumed.
- Pointer is ADDR_W bits, never wraps; the last legal write goes to address 2^ADDR_W-1.

## Timing

- Reset (rst_n=0 at edge): mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, full=0, err_illegal=0, state LOAD; in_ready=1 from the first cycle after reset.
- Latency: accept at edge k -> mem_we=1 with mem_addr/mem_wdata valid during cycle k+1 (registered outputs).
- Throughput: one word per cycle; back-to-back accepts give consecutive strobes on ascending addresses.
- mem_we high for exactly one cycle per legal accept; mem_addr/mem_wdata hold last value when mem_we=0.
- full asserts in the cycle after the final legal accept, the same cycle as the final mem_we. in_ready falls combinationally with full.
- clear with in_valid in the same cycle: clear wins, no accept, no write. Any pending strobe from the previous edge still completes.
- rst_n low mid-stream: pending write dropped (mem_we=0 next cycle), all state to reset values.

## Test plan

- Reset, then ADD rs=1 rt=2 rd=3 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x64221820; word_count=1.
- Back-to-back MUL rs=1 rt=2 rd=5, LW rs=0 rt=4 imm=8, JMP target=0x10 -> 0x64222832 @0, 0xBC040008 @1, 0x08000010 @2 on consecutive cycles.
- op=12 mid-stream between two ADDIs -> err_illegal=1, no strobe for it, ADDIs at addresses 0 and 1, word_count=2.
- ADDR_W=2: five legal requests held valid -> writes at 0..3, full=1 with the 4th strobe, in_ready=0, 5th not consumed; clear -> full=0, next write at address 0.
- clear and in_valid asserted together -> no write, word_count=0; rst_n low one cycle after an accept -> no mem_we, all outputs 0.
